// File: rtl/dmac_seq_mac.sv
// Sequential unsigned multiply-accumulate: shift-add multiply then accumulate,
// both time-shared on one external 64-bit adder (operands out, sum back in).
module dmac_seq_mac #(
    parameter int OP_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                op_start,
    input  logic                op_clear,
    input  logic [OP_W-1:0]     mcand,
    input  logic [OP_W-1:0]     mplier,
    output logic [2*OP_W-1:0]   add_a,
    output logic [2*OP_W-1:0]   add_b,
    output logic                add_ci,
    input  logic [2*OP_W-1:0]   add_s,
    input  logic                add_co,
    output logic                busy,
    output logic                op_done,
    output logic [2*OP_W-1:0]   acc,
    output logic                overflow,
    output logic [1:0]          dbg_state
);

    localparam int CNT_W = $clog2(OP_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [OP_W-1:0]      r_mcand;
    logic [OP_W-1:0]      r_mplier;
    logic [2*OP_W-1:0]    r_prod;
    logic [CNT_W-1:0]     r_count;
    logic [2*OP_W-1:0]    r_acc;
    logic                 r_overflow;
    logic                 r_busy;
    logic                 r_op_done;
    logic [2*OP_W-1:0]    w_partial;

    // Request/status semantics: op_start/op_clear are taken only on an edge where
    // busy is low; busy rises on the accepting edge and op_done pulses for the
    // single cycle in which acc first shows the new result. Nothing is queued.

    always_comb begin
        w_partial = '0;
        if (r_mplier[r_count]) begin
            w_partial = {{OP_W{1'b0}}, r_mcand} << r_count;
        end
    end

    // Operands depend only on registered state, so add_s never loops back to them.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (r_state)
            ST_MUL: begin
                add_a = r_prod;
                add_b = w_partial;
            end
            ST_ACC: begin
                add_a = r_acc;
                add_b = r_prod;
            end
            default: begin
                add_a = '0;
                add_b = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_prod     <= '0;
            r_count    <= '0;
            r_acc      <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_op_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (op_clear) begin
                        r_acc      <= '0;
                        r_overflow <= 1'b0;
                    end
                    if (op_start) begin
                        r_mcand  <= mcand;
                        r_mplier <= mplier;
                        r_prod   <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    // Carry-out cannot occur while summing partial products.
                    r_prod  <= add_s;
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(OP_W - 1)) begin
                        r_state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    r_acc      <= add_s;
                    r_overflow <= r_overflow | add_co;
                    r_op_done  <= 1'b1;
                    r_state    <= ST_DONE;
                end
                ST_DONE: begin
                    r_op_done <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign add_ci    = 1'b0;
    assign busy      = r_busy;
    assign op_done   = r_op_done;
    assign acc       = r_acc;
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dmac_seq_mac.sv
// Bench for dmac_seq_mac: ideal 64-bit adder, directed and random MAC operations
// checked against an arithmetic acc += mcand*mplier model.
module tb_dmac_seq_mac;

    localparam int OP_W = 32;
    localparam int W    = 2 * OP_W;

    logic            clk      = 1'b0;
    logic            reset_n  = 1'b1;
    logic            op_start = 1'b0;
    logic            op_clear = 1'b0;
    logic [OP_W-1:0] mcand    = '0;
    logic [OP_W-1:0] mplier   = '0;
    logic [W-1:0]    add_a;
    logic [W-1:0]    add_b;
    logic            add_ci;
    logic [W-1:0]    add_s;
    logic            add_co;
    logic            busy;
    logic            op_done;
    logic [W-1:0]    acc;
    logic            overflow;
    logic [1:0]      dbg_state;

    int checks      = 0;
    int failures    = 0;
    int done_pulses = 0;

    logic [W-1:0] m_acc = '0;
    logic         m_ovf = 1'b0;
    logic [W-1:0] exp_q[$];

    dmac_seq_mac #(.OP_W(OP_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op_start  (op_start),
        .op_clear  (op_clear),
        .mcand     (mcand),
        .mplier    (mplier),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_s     (add_s),
        .add_co    (add_co),
        .busy      (busy),
        .op_done   (op_done),
        .acc       (acc),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    // Behavioural stand-in for the external carry-lookahead adder.
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && op_done) done_pulses++;
    end

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_op(input logic [OP_W-1:0] mc, input logic [OP_W-1:0] mp, input bit clr);
        logic [W:0] sum;
        if (clr) begin
            m_acc = '0;
            m_ovf = 1'b0;
        end
        sum   = {1'b0, m_acc} + {1'b0, W'(mc) * W'(mp)};
        m_acc = sum[W-1:0];
        m_ovf = m_ovf | sum[W];
        exp_q.push_back(m_acc);
    endtask

    task automatic run_op(input logic [OP_W-1:0] mc, input logic [OP_W-1:0] mp,
                          input bit clr, input bit inject);
        int lat;
        bit seen;
        int pulses0;
        @(negedge clk);
        op_start = 1'b1;
        op_clear = clr;
        mcand    = mc;
        mplier   = mp;
        model_op(mc, mp, clr);
        pulses0 = done_pulses;
        @(posedge clk); #1;
        op_start = 1'b0;
        op_clear = 1'b0;
        mcand    = $urandom;
        mplier   = $urandom;
        check("busy_after_accept", W'(busy), W'(1'b1));
        check("add_ci_zero", W'(add_ci), '0);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            if (inject && lat == 10) begin
                op_start = 1'b1;
                op_clear = 1'b1;
                mcand    = $urandom;
                mplier   = $urandom;
            end
            @(posedge clk); #1;
            lat++;
            if (inject && lat == 11) begin
                op_start = 1'b0;
                op_clear = 1'b0;
            end
            if (op_done) seen = 1'b1;
        end
        check("done_latency", W'(lat), W'(33));
        check("acc_result", acc, exp_q.pop_front());
        check("overflow", W'(overflow), W'(m_ovf));
        check("busy_during_done", W'(busy), W'(1'b1));
        @(posedge clk); #1;
        check("done_one_cycle", W'(op_done), '0);
        check("busy_low_after", W'(busy), '0);
        check("idle_add_a", add_a, '0);
        check("idle_add_b", add_b, '0);
        check("single_done_pulse", W'(done_pulses - pulses0), W'(1));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int pulses0;
        logic [OP_W-1:0] rmc;
        logic [OP_W-1:0] rmp;

        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", W'(busy), '0);
        check("rst_op_done", W'(op_done), '0);
        check("rst_acc", acc, '0);
        check("rst_overflow", W'(overflow), '0);
        check("rst_add_a", add_a, '0);
        check("rst_add_b", add_b, '0);
        check("rst_add_ci", W'(add_ci), '0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // small product from acc=0
        run_op(32'd3, 32'd5, 1'b0, 1'b0);
        check("t1_acc_const", acc, 64'h0000_0000_0000_000F);

        // all-ones squared twice: second accumulate wraps and sets overflow
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        check("t2a_acc_const", acc, 64'hFFFF_FFFE_0000_0001);
        check("t2a_ovf_const", W'(overflow), '0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("t2b_acc_const", acc, 64'hFFFF_FFFC_0000_0002);
        check("t2b_ovf_const", W'(overflow), W'(1'b1));

        // clear+start together replaces acc with the product and drops overflow
        run_op(32'd4, 32'd4, 1'b1, 1'b0);
        check("t3_pre_acc", acc, 64'h10);
        run_op(32'd7, 32'd6, 1'b1, 1'b0);
        check("t3_acc_const", acc, 64'h2A);
        check("t3_ovf_const", W'(overflow), '0);

        // start/clear pulsed mid-multiply are ignored
        run_op(32'd1000, 32'd2000, 1'b0, 1'b1);
        check("t4_acc_const", acc, 64'h2A + 64'd2000000);

        // zero operands leave acc unchanged, same latency
        run_op(32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("t6a_acc_unch", acc, 64'h2A + 64'd2000000);
        run_op(32'h1234_5678, 32'd0, 1'b0, 1'b0);
        check("t6b_acc_unch", acc, 64'h2A + 64'd2000000);

        // random operations, with occasional clears and all-ones operands
        for (int i = 0; i < 10; i++) begin
            rmc = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            rmp = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            run_op(rmc, rmp, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
        end

        // asynchronous reset during multiply at count=10
        @(negedge clk);
        op_start = 1'b1;
        mcand    = 32'h0000_FFFF;
        mplier   = 32'h0000_FFFF;
        @(posedge clk); #1;
        op_start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        m_acc = '0;
        m_ovf = 1'b0;
        pulses0 = done_pulses;
        check("t5_busy", W'(busy), '0);
        check("t5_acc", acc, m_acc);
        check("t5_overflow", W'(overflow), W'(m_ovf));
        check("t5_add_a", add_a, '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("t5_no_done", W'(done_pulses - pulses0), '0);
        check("t5_still_idle", W'(busy), '0);

        // normal operation resumes after reset
        run_op(32'd9, 32'd11, 1'b0, 1'b0);
        check("post_rst_acc", acc, 64'd99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
